// File: rtl/decode_stage_pkg.sv
// Shared constants for the decode stage: widths, RV32I opcodes and FSM state encodings.
package decode_stage_pkg;

   localparam int INST_SIZE = 32;
   localparam logic [INST_SIZE-1:0] INST_SIZE_ZEROS = '0;
   localparam int INCR_SIZE = 4;

   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_OPIMM  = 7'h13;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_SYSTEM = 7'h73;

   typedef enum logic {
      RUN    = 1'b0,
      SQUASH = 1'b1
   } state_t;

   function automatic logic is_known_opcode(input logic [6:0] op);
      logic known;
      case (op)
         OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP,
         OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: known = 1'b1;
         default: known = 1'b0;
      endcase
      return known;
   endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator; unknown opcodes and R-type yield zero.
module imm_gen #(
   parameter int INST_SIZE = decode_stage_pkg::INST_SIZE
) (
   input  logic [INST_SIZE-1:0] instr,
   output logic [INST_SIZE-1:0] imm
);
   import decode_stage_pkg::*;

   logic sign;
   assign sign = instr[31];

   always_comb begin
      imm = '0;
      case (instr[6:0])
         OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM:
            imm = {{(INST_SIZE-12){sign}}, instr[31:20]};
         OPC_STORE:
            imm = {{(INST_SIZE-12){sign}}, instr[31:25], instr[11:7]};
         OPC_BRANCH:
            imm = {{(INST_SIZE-13){sign}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            imm = INST_SIZE'({instr[31:12], 12'b0});
         OPC_JAL:
            imm = {{(INST_SIZE-21){sign}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default:
            imm = '0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate decode into ID/EX, JAL redirect and wrong-path squash.
// Optional ILLEGAL_TRAP_EN flags unknown opcodes on illegal_E.
module decode_stage #(
   parameter int INST_SIZE    = decode_stage_pkg::INST_SIZE,
   parameter int SQUASH_DEPTH = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [INST_SIZE-1:0] InstrD,
   input  logic [INST_SIZE-1:0] PC_DE,
   input  logic                 ex_flush,
   output logic                 PC_R,
   output logic [INST_SIZE-1:0] PC_EX,
   output logic [INST_SIZE-1:0] PC_DISP,
   output logic                 valid_E,
   output logic [INST_SIZE-1:0] pc_E,
   output logic [6:0]           opcode_E,
   output logic [4:0]           rd_E,
   output logic [4:0]           rs1_E,
   output logic [4:0]           rs2_E,
   output logic [2:0]           funct3_E,
   output logic [6:0]           funct7_E,
   output logic [INST_SIZE-1:0] imm_E,
   output logic                 illegal_E
);
   import decode_stage_pkg::*;

   localparam int CNT_W = (SQUASH_DEPTH > 1) ? $clog2(SQUASH_DEPTH + 1) : 1;

   state_t             state_reg;
   logic [CNT_W-1:0]   sq_cnt_reg;
   logic [6:0]         opcode;
   logic [INST_SIZE-1:0] imm;
   logic               live;
   logic               sq_done;
   logic               illegal_next;

   assign opcode = InstrD[6:0];

   imm_gen #(.INST_SIZE(INST_SIZE)) u_imm_gen (
      .instr (InstrD),
      .imm   (imm)
   );

   // rst is folded in so the redirect port reads zero throughout an async reset
   assign live    = !rst && (InstrD != '0) && (state_reg == RUN) && !ex_flush;
   assign PC_R    = live && (opcode == OPC_JAL);
   assign PC_EX   = PC_R ? PC_DE : '0;
   assign PC_DISP = PC_R ? imm : '0;

   assign sq_done = (sq_cnt_reg <= CNT_W'(1));

`ifdef ILLEGAL_TRAP_EN
   assign illegal_next = !is_known_opcode(opcode);
`else
   assign illegal_next = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= RUN;
         sq_cnt_reg <= '0;
         valid_E    <= 1'b0;
         pc_E       <= '0;
         opcode_E   <= '0;
         rd_E       <= '0;
         rs1_E      <= '0;
         rs2_E      <= '0;
         funct3_E   <= '0;
         funct7_E   <= '0;
         imm_E      <= '0;
         illegal_E  <= 1'b0;
      end else begin
         case (state_reg)
            RUN: begin
               if (ex_flush || PC_R) begin
                  state_reg  <= SQUASH;
                  sq_cnt_reg <= CNT_W'(SQUASH_DEPTH);
               end
            end
            SQUASH: begin
               // a late execute flush restarts the kill window from the top
               if (ex_flush) begin
                  sq_cnt_reg <= CNT_W'(SQUASH_DEPTH);
               end else if (sq_done) begin
                  state_reg  <= RUN;
                  sq_cnt_reg <= '0;
               end else begin
                  sq_cnt_reg <= sq_cnt_reg - CNT_W'(1);
               end
            end
            default: state_reg <= RUN;
         endcase

         if (live) begin
            valid_E   <= 1'b1;
            pc_E      <= PC_DE;
            opcode_E  <= opcode;
            rd_E      <= InstrD[11:7];
            rs1_E     <= InstrD[19:15];
            rs2_E     <= InstrD[24:20];
            funct3_E  <= InstrD[14:12];
            funct7_E  <= InstrD[31:25];
            imm_E     <= imm;
            illegal_E <= illegal_next;
         end else begin
            valid_E   <= 1'b0;
            pc_E      <= '0;
            opcode_E  <= '0;
            rd_E      <= '0;
            rs1_E     <= '0;
            rs2_E     <= '0;
            funct3_E  <= '0;
            funct7_E  <= '0;
            imm_E     <= '0;
            illegal_E <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage with hand-computed expectations.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] InstrD;
   logic [31:0] PC_DE;
   logic        ex_flush;
   logic        PC_R;
   logic [31:0] PC_EX, PC_DISP;
   logic        valid_E;
   logic [31:0] pc_E;
   logic [6:0]  opcode_E;
   logic [4:0]  rd_E, rs1_E, rs2_E;
   logic [2:0]  funct3_E;
   logic [6:0]  funct7_E;
   logic [31:0] imm_E;
   logic        illegal_E;

   int tests_run = 0;
   int tests_failed = 0;

   localparam logic [31:0] ADDI_X1_5  = 32'h0050_0093;
   localparam logic [31:0] ADDI_X2_7  = 32'h0070_0113;
   localparam logic [31:0] JAL_X1_16  = 32'h0100_00EF;
   localparam logic [31:0] BEQ_M4     = 32'hFE00_0EE3;
   localparam logic [31:0] LUI_X5     = 32'h1234_52B7;
   localparam logic [31:0] SW_M8      = 32'hFE20_AC23;
   localparam logic [31:0] SUB_X3     = 32'h4020_81B3;
   localparam logic [31:0] ILLEGAL_7F = 32'h0000_007F;

   decode_stage dut (
      .clk       (clk),
      .rst       (rst),
      .InstrD    (InstrD),
      .PC_DE     (PC_DE),
      .ex_flush  (ex_flush),
      .PC_R      (PC_R),
      .PC_EX     (PC_EX),
      .PC_DISP   (PC_DISP),
      .valid_E   (valid_E),
      .pc_E      (pc_E),
      .opcode_E  (opcode_E),
      .rd_E      (rd_E),
      .rs1_E     (rs1_E),
      .rs2_E     (rs2_E),
      .funct3_E  (funct3_E),
      .funct7_E  (funct7_E),
      .imm_E     (imm_E),
      .illegal_E (illegal_E)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // present one decode slot at the falling edge so comb outputs can be sampled before the rising edge
   task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic flush);
      @(negedge clk);
      InstrD   = instr;
      PC_DE    = pc;
      ex_flush = flush;
      #1;
      $display("[TB] slot pc=0x%08h instr=0x%08h ex_flush=%0b PC_R=%0b", pc, instr, flush, PC_R);
   endtask

   task automatic latch;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst      = 1'b1;
      InstrD   = ADDI_X1_5;
      PC_DE    = 32'h8;
      ex_flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(valid_E), 32'h0);
      check("rst_opcode", 32'(opcode_E), 32'h0);
      check("rst_imm", imm_E, 32'h0);
      check("rst_pc", pc_E, 32'h0);
      InstrD = JAL_X1_16;
      PC_DE  = 32'h10;
      #1;
      check("rst_pc_r", 32'(PC_R), 32'h0);
      check("rst_pc_ex", PC_EX, 32'h0);
      check("rst_pc_disp", PC_DISP, 32'h0);

      @(negedge clk);
      rst    = 1'b0;
      InstrD = 32'h0;

      drive(ADDI_X1_5, 32'h8, 1'b0);
      latch();
      check("addi_valid", 32'(valid_E), 32'h1);
      check("addi_opcode", 32'(opcode_E), 32'h13);
      check("addi_rd", 32'(rd_E), 32'h1);
      check("addi_rs1", 32'(rs1_E), 32'h0);
      check("addi_imm", imm_E, 32'h5);
      check("addi_pc", pc_E, 32'h8);
      check("addi_illegal", 32'(illegal_E), 32'h0);

      drive(JAL_X1_16, 32'h10, 1'b0);
      check("jal_pc_r", 32'(PC_R), 32'h1);
      check("jal_pc_ex", PC_EX, 32'h10);
      check("jal_pc_disp", PC_DISP, 32'h10);
      latch();
      check("jal_valid", 32'(valid_E), 32'h1);
      check("jal_pc", pc_E, 32'h10);
      check("jal_rd", 32'(rd_E), 32'h1);

      drive(JAL_X1_16, 32'h14, 1'b0);
      check("squash_pc_r", 32'(PC_R), 32'h0);
      latch();
      check("squash_valid", 32'(valid_E), 32'h0);
      check("squash_pc", pc_E, 32'h0);

      drive(ADDI_X2_7, 32'h20, 1'b0);
      latch();
      check("target_valid", 32'(valid_E), 32'h1);
      check("target_pc", pc_E, 32'h20);
      check("target_rd", 32'(rd_E), 32'h2);
      check("target_imm", imm_E, 32'h7);

      drive(BEQ_M4, 32'h24, 1'b0);
      check("beq_pc_r", 32'(PC_R), 32'h0);
      latch();
      check("beq_valid", 32'(valid_E), 32'h1);
      check("beq_imm", imm_E, 32'hFFFF_FFFC);
      check("beq_opcode", 32'(opcode_E), 32'h63);

      drive(JAL_X1_16, 32'h30, 1'b1);
      check("flush_pc_r", 32'(PC_R), 32'h0);
      check("flush_pc_ex", PC_EX, 32'h0);
      latch();
      check("flush_valid", 32'(valid_E), 32'h0);
      drive(ADDI_X1_5, 32'h34, 1'b0);
      latch();
      check("flush_next_valid", 32'(valid_E), 32'h0);
      drive(ADDI_X1_5, 32'h38, 1'b0);
      latch();
      check("flush_resume_valid", 32'(valid_E), 32'h1);
      check("flush_resume_pc", pc_E, 32'h38);

      drive(JAL_X1_16, 32'h40, 1'b0);
      latch();
      drive(ADDI_X1_5, 32'h44, 1'b1);
      latch();
      check("sq_flush_valid", 32'(valid_E), 32'h0);
      drive(ADDI_X1_5, 32'h48, 1'b0);
      latch();
      check("sq_reload_valid", 32'(valid_E), 32'h0);
      drive(ADDI_X1_5, 32'h4C, 1'b0);
      latch();
      check("sq_exit_valid", 32'(valid_E), 32'h1);
      check("sq_exit_pc", pc_E, 32'h4C);

      drive(ILLEGAL_7F, 32'h50, 1'b0);
      check("ill_pc_r", 32'(PC_R), 32'h0);
      latch();
      check("ill_valid", 32'(valid_E), 32'h1);
      check("ill_imm", imm_E, 32'h0);
`ifdef ILLEGAL_TRAP_EN
      check("ill_flag", 32'(illegal_E), 32'h1);
`else
      check("ill_flag", 32'(illegal_E), 32'h0);
`endif

      drive(LUI_X5, 32'h54, 1'b0);
      latch();
      check("lui_imm", imm_E, 32'h1234_5000);
      check("lui_rd", 32'(rd_E), 32'h5);

      drive(SW_M8, 32'h58, 1'b0);
      latch();
      check("sw_imm", imm_E, 32'hFFFF_FFF8);
      check("sw_rs2", 32'(rs2_E), 32'h2);
      check("sw_funct3", 32'(funct3_E), 32'h2);

      drive(SUB_X3, 32'h5C, 1'b0);
      latch();
      check("sub_imm", imm_E, 32'h0);
      check("sub_funct7", 32'(funct7_E), 32'h20);
      check("sub_rd", 32'(rd_E), 32'h3);

      drive(32'h0, 32'h60, 1'b0);
      latch();
      check("bubble_valid", 32'(valid_E), 32'h0);

      drive(JAL_X1_16, 32'h60, 1'b0);
      latch();
      check("mid_jal_valid", 32'(valid_E), 32'h1);
      #1;
      rst    = 1'b1;
      InstrD = 32'h0;
      #1;
      check("async_rst_valid", 32'(valid_E), 32'h0);
      check("async_rst_pc", pc_E, 32'h0);
      @(negedge clk);
      rst    = 1'b0;
      InstrD = ADDI_X1_5;
      PC_DE  = 32'h64;
      $display("[TB] slot pc=0x%08h instr=0x%08h after reset", PC_DE, InstrD);
      latch();
      check("post_rst_valid", 32'(valid_E), 32'h1);
      check("post_rst_pc", pc_E, 32'h64);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Consumer end of the fetch→decode interface: takes InstrD/PC_DE from the fetch stage, decodes RV32I fields and immediates, and registers them into the ID/EX pipeline register.
- Producer end of the fetch redirect interface (PC_R, PC_EX, PC_DISP): resolves JAL in decode and squashes wrong-path fetch slots after a decode or execute redirect.

Parameters:
- INST_SIZE, 32, instruction/PC width (from shared constants).
- SQUASH_DEPTH, 1, wrong-path slots killed after a decode redirect (1 matches the one-cycle fetch register).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- InstrD  input  INST_SIZE  instruction from fetch; all-zero = bubble.
- PC_DE  input  INST_SIZE  PC of InstrD.
- ex_flush  input  1  execute stage taken branch/JALR this cycle; current and next decode slots are wrong-path.
- PC_R  output  1  redirect request to fetch (combinational).
- PC_EX  output  INST_SIZE  redirect base = PC_DE.
- PC_DISP  output  INST_SIZE  redirect displacement = J-immediate.
- valid_E  output  1  ID/EX slot holds a live instruction.
- pc_E  output  INST_SIZE  registered PC.
- opcode_E  output  7  registered opcode.
- rd_E, rs1_E, rs2_E  output  5 each  register indices.
- funct3_E  output  3.
- funct7_E  output  7.
- imm_E  output  INST_SIZE  sign-extended immediate.
- illegal_E  output  1  unknown opcode flag (see Optional Feature).

Behaviour:
- Reset: while rst=1 every registered output is 0, state=RUN, and PC_R/PC_EX/PC_DISP are forced to 0. Asynchronous; a mid-squash reset abandons the squash.
- live = (InstrD != 0) && state==RUN && !ex_flush.
- Immediate by opcode:
  - I (0x03, 0x13, 0x67, 0x73): inst[31:20].
  - S (0x23).
  - B (0x63): bit0=0.
  - U (0x37, 0x17): inst[31:12]<<12.
  - J (0x6F): bit0=0.
  - R (0x33): 0.
  - All sign-extended from inst[31] except U.
- Latency: 1 cycle InstrD→*_E. If !live: valid_E=0 and all *_E fields 0. Otherwise fields are loaded and valid_E=1.
- PC_R = live && opcode==JAL. When asserted, PC_EX=PC_DE and PC_DISP=immJ; otherwise both 0. Fetch's next PC is then PC_DE+immJ. The JAL itself proceeds to EX (valid_E=1) for the link write.
- FSM states: RUN, SQUASH. A counter sq_cnt is used only with SQUASH_DEPTH>1.
  - RUN→SQUASH: on PC_R, or on ex_flush; sq_cnt loads SQUASH_DEPTH.
  - SQUASH: current slot killed, PC_R=0. sq_cnt decrements; →RUN when it reaches 0.
  - ex_flush in SQUASH reloads sq_cnt and stays in SQUASH.
- Simultaneous JAL and ex_flush: ex_flush wins. No PC_R, slot killed, enter SQUASH.
- JALR and conditional branches are not resolved here; they pass to EX untouched.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an opcode not in {0x03, 0x13, 0x17, 0x23, 0x33, 0x37, 0x63, 0x67, 0x6F, 0x73} sets illegal_E=1 with valid_E=1 and imm_E=0, and never raises PC_R.
- Undefined: illegal_E is tied 0 and unknown opcodes pass with imm_E=0.

Decomposition:
- Shared constants/package: INST_SIZE, INST_SIZE_ZEROS, INCR_SIZE, the opcode constants listed above, and the FSM state encodings.
- Sub-module imm_gen: combinational, InstrD→imm, per the format table.

Test Plan:
- Reset: rst=1 with InstrD=0x00500093 → all *_E=0, PC_R=0. Release rst → decode resumes next edge.
- ADDI x1,x0,5 (0x00500093) at PC 0x8 → next cycle valid_E=1, opcode_E=0x13, rd_E=1, rs1_E=0, imm_E=5, pc_E=0x8.
- JAL x1,+16 (0x010000EF) at PC 0x10 → same cycle PC_R=1, PC_EX=0x10, PC_DISP=0x10. Next cycle valid_E=1, pc_E=0x10. The instruction at 0x14 presented in the following cycle is killed (valid_E=0). The instruction at 0x20 is decoded normally.
- BEQ x0,x0,-4 (0xFE000EE3) → imm_E=0xFFFFFFFC, PC_R=0, valid_E=1.
- ex_flush=1 with JAL in decode → PC_R=0. Next cycle valid_E=0. The following slot is also killed, then RUN.
- Illegal opcode: InstrD=0x0000007F → with ILLEGAL_TRAP_EN, illegal_E=1 and valid_E=1; without it, illegal_E=0.
